apu_sample_capture: RTL

- Downstream consumer of the APU channel DAC inputs (ch1_out, ch2_out, wave_dac_d, ch4_out) and the mixer routing/volume state.
- Performs the NR51 panning and NR50 master-volume mix digitally.
- Boxcar-decimates the mix to a host sample rate and buffers signed 16-bit stereo PCM in a small FIFO behind a valid/ready port.
- Lets the testbench dump audio alongside the gate-level simulation.

---
 rtl/apu_sample_capture.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/apu_sample_capture.sv
// APU audio capture: NR51/NR50 digital mix, boxcar decimation, stereo PCM FIFO.
// Optional per-side DC-blocking filter enabled by defining APU_CAPTURE_HPF_EN.
module apu_sample_capture #(
  parameter int DIV        = 95,
  parameter int SHIFT      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        apuv_4mhz,
  input  logic        reset,
  input  logic [3:0]  ch1_out,
  input  logic [3:0]  ch2_out,
  input  logic [3:0]  wave_dac_d,
  input  logic [3:0]  ch4_out,
  input  logic        nch1_amp_en,
  input  logic        nch2_amp_en,
  input  logic        ch3_active,
  input  logic        nch4_amp_en,
  input  logic        namp_en,
  input  logic [7:0]  nr51,
  input  logic [2:0]  nr50_lvol,
  input  logic [2:0]  nr50_rvol,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [7:0]  drop_cnt
);
  localparam int        AW   = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST = 8'(DIV - 1);

  // Channel index 0..3 = ch1..ch4; side 0 = right (nr51[3:0]), side 1 = left.
  logic [3:0][3:0] code;
  logic [3:0]      ch_en;
  assign code  = {ch4_out, wave_dac_d, ch2_out, ch1_out};
  assign ch_en = {~nch4_amp_en, ch3_active, ~nch2_amp_en, ~nch1_amp_en} & {4{~namp_en}};

  logic signed [10:0] mix  [2];
  logic signed [10:0] gain [2];
  logic signed [10:0] prod [2];
  logic [2:0]         vol  [2];

  always_comb begin
    vol[0] = nr50_rvol;
    vol[1] = nr50_lvol;
    for (int s = 0; s < 2; s++) begin
      mix[s] = '0;
      for (int c = 0; c < 4; c++)
        if (ch_en[c] && nr51[4*s+c])
          mix[s] = mix[s] + ($signed({6'd0, code[c], 1'b0}) - 11'sd15);
      gain[s] = $signed({8'd0, vol[s]}) + 11'sd1;
      prod[s] = mix[s] * gain[s];
    end
  end

  logic [7:0]         cnt_q, cnt_d;
  logic signed [17:0] acc_q [2];
  logic signed [17:0] acc_d [2];
  logic signed [17:0] win   [2];
  logic signed [17:0] shf   [2];
  logic signed [15:0] sat   [2];
  logic signed [15:0] push_val [2];
  logic               win_end;

  assign win_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = win_end ? 8'd0 : cnt_q + 8'd1;
    for (int s = 0; s < 2; s++) begin
      win[s] = acc_q[s] + prod[s];
      shf[s] = win[s] >>> SHIFT;
      if (shf[s] > 18'sd32767)       sat[s] = 16'sh7fff;
      else if (shf[s] < -18'sd32768) sat[s] = 16'sh8000;
      else                           sat[s] = shf[s][15:0];
      acc_d[s] = win_end ? 18'sd0 : win[s];
    end
  end

`ifdef APU_CAPTURE_HPF_EN
  // DC blocker: y = x - x_prev + y_prev - y_prev/256, stepped once per window.
  logic signed [17:0] xp_q [2];
  logic signed [17:0] xp_d [2];
  logic signed [17:0] yp_q [2];
  logic signed [17:0] yp_d [2];
  logic signed [19:0] y_full [2];

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      y_full[s] = 20'(sat[s]) - 20'(xp_q[s]) + 20'(yp_q[s]) - 20'(yp_q[s] >>> 8);
      if (y_full[s] > 20'sd32767)       push_val[s] = 16'sh7fff;
      else if (y_full[s] < -20'sd32768) push_val[s] = 16'sh8000;
      else                              push_val[s] = y_full[s][15:0];
      xp_d[s] = win_end ? 18'(sat[s])      : xp_q[s];
      yp_d[s] = win_end ? 18'(push_val[s]) : yp_q[s];
    end
  end

  always_ff @(posedge apuv_4mhz) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        xp_q[s] <= '0;
        yp_q[s] <= '0;
      end else begin
        xp_q[s] <= xp_d[s];
        yp_q[s] <= yp_d[s];
      end
    end
  end
`else
  always_comb begin
    for (int s = 0; s < 2; s++) push_val[s] = sat[s];
  end
`endif

  // FIFO of {left, right}; pointers carry an extra wrap bit.
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [31:0] mem_d [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0] last_q, last_d, head;
  logic [7:0]  drop_q, drop_d;
  logic        empty, full, pop, push, drop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign pop   = !empty && sample_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push  = win_end && (!full || pop);
  assign drop  = win_end && full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q[AW-1:0]] = {push_val[1], push_val[0]};
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    last_d = pop  ? head : last_q;
    drop_d = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge apuv_4mhz) begin
    mem_q <= mem_d;
    if (reset) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= '0;
      drop_q <= '0;
      for (int s = 0; s < 2; s++) acc_q[s] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
      drop_q <= drop_d;
      for (int s = 0; s < 2; s++) acc_q[s] <= acc_d[s];
    end
  end

  assign sample_valid = !empty;
  assign sample_l     = empty ? last_q[31:16] : head[31:16];
  assign sample_r     = empty ? last_q[15:0]  : head[15:0];
  assign drop_cnt     = drop_q;

endmodule
